clk_divider: RTL and testbench

Programmable clock-enable divider sitting directly downstream of the clock-test/enable stage: it consumes that stage's enable level and produces a divided, registered `clkout` square wave plus a one-cycle `tick` strobe, both synchronous to `clock`. The divisor is loaded at runtime through a valid/ready handshake. New divisors take effect only at period boundaries, so the output never produces runt pulses.

---
 rtl/clk_divider_pkg.sv | 11 +
 rtl/clk_divider_cnt.sv | 41 ++++
 rtl/clk_divider.sv | 131 +++++++++++++
 tb/tb_clk_divider.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_divider_pkg.sv
// Shared types and constants for the programmable clock-enable divider.
package clk_divider_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned CLK_DIV_MIN = 2;

endpackage

// File: rtl/clk_divider_cnt.sv
// Period counter for clk_divider: counts 0..div-1 while running, flags the
// period end and whether the next count lies in the high phase.
module clk_divider_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [DIV_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             next_high_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   half_len;

  // One extra bit so the rounding-up add cannot overflow at the max divisor.
  assign half_len = ({1'b0, div_i} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

  assign wrap_o = run_i && (cnt_q == (div_i - {{(DIV_W-1){1'b0}}, 1'b1}));

  always_comb begin
    cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    if (!run_i || wrap_o) begin
      cnt_d = '0;
    end
  end

  assign next_high_o = ({1'b0, cnt_d} < half_len);
  assign cnt_o       = cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_divider.sv
// Programmable clock-enable divider with valid/ready divisor load applied at
// period boundaries. Optional macro CLK_DIVIDER_PERIOD_COUNT_EN adds period_count.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_valid,
  input  logic [DIV_W-1:0] div_value,
  output logic             div_ready,
  output logic             clkout,
  output logic             tick,
`ifdef CLK_DIVIDER_PERIOD_COUNT_EN
  output logic [31:0]      period_count,
`endif
  output logic             busy
);

  localparam logic [DIV_W-1:0] DIV_MIN_W = DIV_W'(CLK_DIV_MIN);
  localparam logic [DIV_W-1:0] DIV_RST_W = DIV_W'(DEFAULT_DIV);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;

  logic             xfer;
  logic [DIV_W-1:0] div_clamped;
  logic             wrap, next_high;
  logic [DIV_W-1:0] unused_cnt;

  clk_divider_cnt #(.DIV_W(DIV_W)) u_cnt (
    .clock       (clock),
    .reset       (reset),
    .run_i       (state_q == ST_RUN),
    .div_i       (div_q),
    .cnt_o       (unused_cnt),
    .wrap_o      (wrap),
    .next_high_o (next_high)
  );

  assign xfer        = div_valid && !pend_q;
  assign div_clamped = (div_value < DIV_MIN_W) ? DIV_MIN_W : div_value;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    pval_d   = pval_q;
    pend_d   = pend_q;
    clkout_d = 1'b0;
    tick_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A divisor caught pending by the final wrap is applied while idle.
        if (pend_q) begin
          div_d  = pval_q;
          pend_d = 1'b0;
        end
        if (xfer) begin
          div_d = div_clamped;
        end
        if (enable) begin
          state_d  = ST_RUN;
          clkout_d = 1'b1;
          tick_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          pval_d = div_clamped;
          pend_d = 1'b1;
        end
        if (wrap && pend_q) begin
          div_d  = pval_q;
          pend_d = 1'b0;
        end
        if (wrap && !enable) begin
          state_d = ST_IDLE;
        end else begin
          clkout_d = next_high;
          tick_d   = next_high && !clkout_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_q    <= DIV_RST_W;
      pval_q   <= '0;
      pend_q   <= 1'b0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      pval_q   <= pval_d;
      pend_q   <= pend_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

`ifdef CLK_DIVIDER_PERIOD_COUNT_EN
  logic [31:0] pcount_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pcount_q <= '0;
    end else if (tick_d) begin
      pcount_q <= pcount_q + 32'd1;
    end
  end

  assign period_count = pcount_q;
`endif

  assign div_ready = !pend_q;
  assign clkout    = clkout_q;
  assign tick      = tick_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: directed literal patterns plus a
// randomized run compared each cycle against a period-position model.
module tb_clk_divider;
  import clk_divider_pkg::*;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        div_valid;
  logic [15:0] div_value;
  logic        div_ready;
  logic        clkout;
  logic        tick;
  logic        busy;
`ifdef CLK_DIVIDER_PERIOD_COUNT_EN
  logic [31:0] period_count;
`endif

  clk_divider #(.DIV_W(16), .DEFAULT_DIV(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .div_valid    (div_valid),
    .div_value    (div_value),
    .div_ready    (div_ready),
    .clkout       (clkout),
    .tick         (tick),
`ifdef CLK_DIVIDER_PERIOD_COUNT_EN
    .period_count (period_count),
`endif
    .busy         (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: position within the current output period, active divisor, pending slot.
  bit          m_started = 0;
  bit          m_run     = 0;
  int unsigned m_pos     = 0;
  int unsigned m_div     = 4;
  bit          m_pend    = 0;
  int unsigned m_pval    = 0;
  int unsigned m_pc      = 0;

  function automatic int unsigned clamp(input int unsigned v);
    return (v < CLK_DIV_MIN) ? CLK_DIV_MIN : v;
  endfunction

  always @(posedge clock) begin
    bit          xfer_m;
    bit          pend_old;
    int unsigned nv;
    xfer_m   = div_valid && !m_pend;
    nv       = clamp(32'(div_value));
    pend_old = m_pend;
    if (reset) begin
      m_started = 1;
      m_run     = 0;
      m_pos     = 0;
      m_div     = 4;
      m_pend    = 0;
      m_pval    = 0;
      m_pc      = 0;
    end else if (m_started) begin
      if (!m_run) begin
        if (pend_old) begin
          m_div  = m_pval;
          m_pend = 0;
        end
        if (xfer_m) m_div = nv;
        if (enable) begin
          m_run = 1;
          m_pos = 0;
        end
      end else begin
        if (xfer_m) begin
          m_pend = 1;
          m_pval = nv;
        end
        if (m_pos == m_div - 1) begin
          if (pend_old) begin
            m_div  = m_pval;
            m_pend = 0;
          end
          if (enable) m_pos = 0;
          else        m_run = 0;
        end else begin
          m_pos++;
        end
      end
      if (m_run && m_pos == 0) m_pc++;
    end
  end

  always @(negedge clock) begin
    if (m_started) begin
      check("clkout", 32'(clkout), 32'(m_run && (m_pos < (m_div + 1) / 2)));
      check("tick",   32'(tick),   32'(m_run && m_pos == 0));
      check("busy",   32'(busy),   32'(m_run));
      check("ready",  32'(div_ready), 32'(!m_pend));
`ifdef CLK_DIVIDER_PERIOD_COUNT_EN
      check("period_count", period_count, m_pc);
`endif
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input int n, output logic [15:0] c_clk, output logic [15:0] c_tick,
                         output logic [15:0] c_busy, output logic [15:0] c_rdy);
    c_clk = '0; c_tick = '0; c_busy = '0; c_rdy = '0;
    for (int i = 0; i < n; i++) begin
      cyc();
      c_clk  = {c_clk[14:0],  clkout};
      c_tick = {c_tick[14:0], tick};
      c_busy = {c_busy[14:0], busy};
      c_rdy  = {c_rdy[14:0],  div_ready};
    end
  endtask

  task automatic stop_run();
    int waited;
    enable = 1'b0;
    waited = 0;
    while (busy && waited < 100) begin
      cyc();
      waited++;
    end
    if (busy) check("stop_timeout", 32'(busy), 32'd0);
  endtask

  task automatic load_idle(input logic [15:0] v);
    div_valid = 1'b1;
    div_value = v;
    cyc();
    div_valid = 1'b0;
  endtask

  logic [15:0] c_clk, c_tick, c_busy, c_rdy;

  initial begin
    reset = 1'b1; enable = 1'b0; div_valid = 1'b0; div_value = '0;
    cyc(); cyc();
    check("rst_clkout", 32'(clkout), 32'd0);
    check("rst_tick",   32'(tick),   32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_ready",  32'(div_ready), 32'd1);
    reset = 1'b0;
    cyc();

    // Default divisor 4.
    enable = 1'b1;
    capture(8, c_clk, c_tick, c_busy, c_rdy);
    check("n4_clkout", 32'(c_clk),  32'b11001100);
    check("n4_tick",   32'(c_tick), 32'b10001000);

    // Idle load of 5.
    stop_run();
    load_idle(16'd5);
    check("idle_load_ready", 32'(div_ready), 32'd1);
    enable = 1'b1;
    capture(10, c_clk, c_tick, c_busy, c_rdy);
    check("n5_clkout", 32'(c_clk),  32'b1110011100);
    check("n5_tick",   32'(c_tick), 32'b1000010000);

    // Run-time change 4 -> 6 offered mid-period.
    stop_run();
    load_idle(16'd4);
    enable = 1'b1;
    cyc(); cyc();
    div_valid = 1'b1; div_value = 16'd6;
    cyc();
    div_valid = 1'b0;
    check("chg_ready_drop", 32'(div_ready), 32'd0);
    capture(8, c_clk, c_tick, c_busy, c_rdy);
    check("chg_tick",   32'(c_tick), 32'b01000001);
    check("chg_ready",  32'(c_rdy),  32'b01111111);
    check("chg_clkout", 32'(c_clk),  32'b01110001);

    // Divisor values 0 and 1 clamp to 2.
    stop_run();
    load_idle(16'd0);
    enable = 1'b1;
    capture(4, c_clk, c_tick, c_busy, c_rdy);
    check("n0_clkout", 32'(c_clk),  32'b1010);
    check("n0_tick",   32'(c_tick), 32'b1010);
    stop_run();
    load_idle(16'd1);
    enable = 1'b1;
    capture(4, c_clk, c_tick, c_busy, c_rdy);
    check("n1_clkout", 32'(c_clk),  32'b1010);

    // Enable dropped in the second cycle of an 8-cycle period.
    stop_run();
    load_idle(16'd8);
    enable = 1'b1;
    cyc(); cyc();
    enable = 1'b0;
    capture(10, c_clk, c_tick, c_busy, c_rdy);
    check("stop_busy",   32'(c_busy), 32'b1111110000);
    check("stop_clkout", 32'(c_clk),  32'b1100000000);
    check("stop_tick",   32'(c_tick), 32'b0000000000);

    // Reset mid-period with a pending divisor.
    enable = 1'b1;
    cyc(); cyc();
    div_valid = 1'b1; div_value = 16'd6;
    cyc();
    div_valid = 1'b0;
    check("pend_ready", 32'(div_ready), 32'd0);
    reset = 1'b1;
    cyc();
    check("mrst_clkout", 32'(clkout), 32'd0);
    check("mrst_tick",   32'(tick),   32'd0);
    check("mrst_busy",   32'(busy),   32'd0);
    check("mrst_ready",  32'(div_ready), 32'd1);
    check("mrst_div_q",  32'(dut.div_q), 32'd4);
`ifdef CLK_DIVIDER_PERIOD_COUNT_EN
    check("mrst_period_count", period_count, 32'd0);
`endif
    reset = 1'b0;
    capture(8, c_clk, c_tick, c_busy, c_rdy);
    check("post_rst_clkout", 32'(c_clk), 32'b11001100);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      div_valid = ($urandom_range(0, 9) < 2);
      div_value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1))
                                              : 16'($urandom_range(2, 9));
      cyc();
    end
    reset = 1'b0; div_valid = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
